// File: rtl/sar_adc_model.sv
// sar_adc_model: behavioural SAR ADC, real input, one bit per clock, valid/ready out.
// Optional: define SAR_ADC_OVR_CNT_EN to add the saturating ovr_count output.
`timescale 1ns/1ps
module sar_adc_model #(
    parameter int  BITS    = 8,
    parameter real VREF_LO = 0.0,
    parameter real VREF_HI = 5.0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  real             vin,
    input  logic            start,
    output logic            busy,
    output logic [BITS-1:0] dout,
    output logic            dout_valid,
    input  logic            dout_ready,
`ifdef SAR_ADC_OVR_CNT_EN
    output logic [15:0]     ovr_count,
`endif
    output logic            ovr
);

    localparam int IW = (BITS > 1) ? $clog2(BITS) : 1;
    localparam real LSB = (VREF_HI - VREF_LO) / real'(2 ** BITS);
    localparam logic [IW-1:0] TOP = IW'(BITS - 1);
    localparam logic [BITS-1:0] ONE = BITS'(1);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        HOLD
    } state_t;

    state_t          state_q, state_d;
    real             vheld_q, vheld_d;
    logic            ovr_next_q, ovr_next_d;
    logic [BITS-1:0] sar_q, sar_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            busy_q, busy_d;
    logic [BITS-1:0] dout_q, dout_d;
    logic            valid_q, valid_d;
    logic            ovr_q, ovr_d;
    logic [BITS-1:0] trial;
    logic            accept;
    logic            capture;
`ifdef SAR_ADC_OVR_CNT_EN
    logic [15:0]     cnt_q, cnt_d;
`endif

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vheld_q    <= 0.0;
            ovr_next_q <= 1'b0;
            sar_q      <= '0;
            idx_q      <= TOP;
            busy_q     <= 1'b0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef SAR_ADC_OVR_CNT_EN
            cnt_q      <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            vheld_q    <= vheld_d;
            ovr_next_q <= ovr_next_d;
            sar_q      <= sar_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
`ifdef SAR_ADC_OVR_CNT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Next state: sample/hold, one SAR trial per edge, result hold until accepted.
    always_comb begin
        state_d    = state_q;
        vheld_d    = vheld_q;
        ovr_next_d = ovr_next_q;
        sar_d      = sar_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        dout_d     = dout_q;
        valid_d    = valid_q;
        ovr_d      = ovr_q;
`ifdef SAR_ADC_OVR_CNT_EN
        cnt_d      = cnt_q;
`endif
        trial   = sar_q | (ONE << idx_q);
        accept  = valid_q && dout_ready;
        capture = start && ((state_q == IDLE) ||
                            ((state_q == HOLD) && accept));

        unique case (state_q)
            IDLE: begin
            end
            CONVERT: begin
                // Inclusive compare: a voltage on a threshold resolves upward.
                if (vheld_q >= VREF_LO + real'(trial) * LSB) begin
                    sar_d = trial;
                end
                if (idx_q == '0) begin
                    state_d = HOLD;
                    dout_d  = sar_d;
                    ovr_d   = ovr_next_q;
                    valid_d = 1'b1;
`ifdef SAR_ADC_OVR_CNT_EN
                    if (ovr_next_q && (cnt_q != 16'hFFFF)) begin
                        cnt_d = cnt_q + 16'd1;
                    end
`endif
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            HOLD: begin
                if (accept) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A capture in HOLD overrides the return to IDLE: back-to-back, busy stays high.
        if (capture) begin
            vheld_d    = vin;
            ovr_next_d = (vin < VREF_LO) || (vin >= VREF_HI);
            sar_d      = '0;
            idx_d      = TOP;
            busy_d     = 1'b1;
            state_d    = CONVERT;
        end
    end

    assign busy       = busy_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign ovr        = ovr_q;
`ifdef SAR_ADC_OVR_CNT_EN
    assign ovr_count  = cnt_q;
`endif

endmodule

// File: tb/tb_sar_adc_model.sv
// tb_sar_adc_model: vector table, hand sequences and random/sine runs
// checked against a conversion-level reference model.
`timescale 1ns/1ps
module tb_sar_adc_model;

    localparam int  BITS = 8;
    localparam real LO   = 0.0;
    localparam real HI   = 5.0;
    localparam real LSB  = (HI - LO) / 256.0;
    localparam int  MAXC = (1 << BITS) - 1;
    localparam real PI   = 3.14159265358979;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic dout_ready = 1'b0;
    real  vin = 0.0;
    logic busy;
    logic dout_valid;
    logic ovr;
    logic [BITS-1:0] dout;
`ifdef SAR_ADC_OVR_CNT_EN
    logic [15:0] ovr_count;
`endif

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sar_adc_model #(
        .BITS(BITS),
        .VREF_LO(LO),
        .VREF_HI(HI)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .vin(vin),
        .start(start),
        .busy(busy),
        .dout(dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
`ifdef SAR_ADC_OVR_CNT_EN
        .ovr_count(ovr_count),
`endif
        .ovr(ovr)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int ref_code(input real v);
        real x;
        x = (v - LO) / LSB;
        if (x < 0.0) return 0;
        if (x >= real'(MAXC + 1)) return MAXC;
        return $rtoi(x);
    endfunction

    function automatic real grid_v(input int n);
        return LO + real'(n) * (LSB / 4.0);
    endfunction

    function automatic real rand_v();
        int n;
        n = int'($urandom_range(0, 1024 + 80)) - 40;
        return grid_v(n);
    endfunction

    // Reference model: conversion-level view (capture, BITS-cycle wait, hold).
    bit m_busy, m_valid, m_ovr, m_po;
    int m_left, m_code, m_pc, m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_ovr <= 1'b0; m_po <= 1'b0;
            m_left <= 0; m_code <= 0; m_pc <= 0; m_cnt <= 0;
        end else begin
            if (m_valid && dout_ready) begin
                m_valid <= 1'b0;
                m_busy  <= 1'b0;
            end else if (m_busy && !m_valid) begin
                if (m_left == 1) begin
                    m_valid <= 1'b1;
                    m_code  <= m_pc;
                    m_ovr   <= m_po;
                    if (m_po && m_cnt < 65535) m_cnt <= m_cnt + 1;
                end
                m_left <= m_left - 1;
            end
            if (start && (!m_busy || (m_valid && dout_ready))) begin
                m_busy <= 1'b1;
                m_left <= BITS;
                m_pc   <= ref_code(vin);
                m_po   <= (vin < LO) || (vin >= HI);
            end
        end
    end

    // Continuous comparison against the model on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("bg_busy", busy, m_busy);
            check("bg_valid", dout_valid, m_valid);
            check("bg_dout", dout, m_code);
            if (m_valid) check("bg_ovr", ovr, m_ovr);
`ifdef SAR_ADC_OVR_CNT_EN
            check("bg_ovr_count", ovr_count, m_cnt);
`endif
        end
    end

    typedef struct {
        real vin;
        int  code;
        bit  ovr;
    } vec_t;

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!dout_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic convert_row(input string tag, input real v, input int code, input bit o);
        int lat;
        vin = v; start = 1'b1; dout_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        wait_valid(lat);
        check({tag, "_lat"}, lat, BITS);
        check({tag, "_code"}, dout, code);
        check({tag, "_ovr"}, ovr, o);
        @(posedge clk); #1;
        check({tag, "_acc_busy"}, busy, 0);
        check({tag, "_acc_valid"}, dout_valid, 0);
    endtask

    initial begin
        vec_t tbl[6];
        int lat, last, gaps_bad, nsamp, min_c, max_c;
        logic [BITS-1:0] held;

        tbl[0] = '{vin: 2.5,  code: 128, ovr: 1'b0};
        tbl[1] = '{vin: 1.0,  code: 51,  ovr: 1'b0};
        tbl[2] = '{vin: 4.99, code: 255, ovr: 1'b0};
        tbl[3] = '{vin: 0.0,  code: 0,   ovr: 1'b0};
        tbl[4] = '{vin: 5.2,  code: 255, ovr: 1'b1};
        tbl[5] = '{vin: -0.3, code: 0,   ovr: 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_ovr", ovr, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Vector table
        foreach (tbl[i]) begin
            convert_row($sformatf("vec%0d", i), tbl[i].vin, tbl[i].code, tbl[i].ovr);
        end
`ifdef SAR_ADC_OVR_CNT_EN
        check("ovr_count_after_table", ovr_count, 2);
`endif

        // Held result under backpressure, start ignored, then back-to-back
        vin = 3.0; start = 1'b1; dout_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid(lat);
        check("hold_lat", lat, BITS);
        check("hold_code", dout, 153);
        held = dout;
        for (int i = 0; i < 20; i++) begin
            vin = rand_v();
            start = 1'(($urandom % 2));
            @(posedge clk); #1;
            check("hold_dout_stable", dout, held);
            check("hold_valid_stable", dout_valid, 1);
            check("hold_ovr_stable", ovr, 0);
            check("hold_busy", busy, 1);
        end
        vin = 1.0; start = 1'b1; dout_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_valid_low", dout_valid, 0);
        wait_valid(lat);
        check("b2b_lat", lat, BITS);
        check("b2b_code", dout, 51);
        @(posedge clk); #1;

        // Input change mid-conversion must not disturb the held sample
        vin = 2.5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vin = 0.0;
        wait_valid(lat);
        check("vchg_lat", lat, BITS - 3);
        check("vchg_code", dout, 128);
        @(posedge clk); #1;

        // Asynchronous reset mid-conversion
        vin = 4.0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", dout_valid, 0);
        check("arst_dout", dout, 0);
        check("arst_ovr", ovr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        convert_row("post_rst", 1.0, 51, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            vin = rand_v();
            start = 1'(($urandom % 2));
            dout_ready = 1'(($urandom % 10) < 7);
            @(posedge clk); #1;
        end
        start = 1'b0; dout_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("drain_idle", busy, 0);

        // Sine drive, start held, ready held
        last = -1; gaps_bad = 0; nsamp = 0; min_c = MAXC; max_c = 0;
        start = 1'b1; dout_ready = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            real s;
            s = 2.5 + 2.5 * $sin(2.0 * PI * $realtime / 1000.0);
            vin = grid_v($rtoi(s / (LSB / 4.0) + 0.5));
            @(posedge clk); #1;
            if (dout_valid) begin
                nsamp++;
                if (last >= 0 && cyc - last != BITS + 1) gaps_bad++;
                last = cyc;
                if (int'(dout) < min_c) min_c = int'(dout);
                if (int'(dout) > max_c) max_c = int'(dout);
            end
        end
        start = 1'b0;
        check("sine_gaps_bad", gaps_bad, 0);
        check("sine_enough_samples", nsamp >= 300, 1);
        check("sine_min_low", min_c <= 1, 1);
        check("sine_max_high", max_c >= 254, 1);
        repeat (12) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
